// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the multi-channel ADC capture engine.
// Holds the capture FSM state encoding, default parameter values and the
// circular-buffer pointer arithmetic helper.
package adc_capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_WAIT_TRIG,
      ST_CAPTURE,
      ST_READOUT
   } cap_state_t;

   localparam int DEF_NUM_CH       = 2;
   localparam int DEF_DATA_W       = 14;
   localparam int DEF_DEPTH        = 1000;
   localparam int DEF_PRE_MAX      = 100;
   localparam int DEF_AUTO_TIMEOUT = 1000000;

   // (a - b) mod depth for a < depth and b <= depth; the depth is passed in
   // because each engine instance may size its buffer differently.
   function automatic int unsigned sub_mod(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned depth);
      return (a >= b) ? (a - b) : (a + depth - b);
   endfunction

endpackage

// File: rtl/adc_capture_engine_edge_trigger.sv
// Level-crossing detector for one ADC channel.
// Latency: combinational (fire is valid in the same cycle as prev/cur).
// Backpressure: none, pure function of its inputs.
// Ports: prev/cur = consecutive samples, level = threshold,
//        slope = 0 rising / 1 falling, fire = crossing detected.
module edge_trigger
   import adc_capture_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [DATA_W-1:0] prev,
   input  logic [DATA_W-1:0] cur,
   input  logic [DATA_W-1:0] level,
   input  logic              slope,
   output logic              fire
);

   always_comb begin
      if (slope) fire = (prev > level) && (cur <= level);
      else       fire = (prev < level) && (cur >= level);
   end

endmodule

// File: rtl/adc_capture_engine.sv
// Multi-channel ADC record capture: circular pre-trigger buffer, level trigger,
// streamed readout. Latency: adc_data to RAM 1 cycle; out_valid 2 cycles after
// READOUT entry. Backpressure: out_valid/out_ready with a one-entry skid, no bubbles.
// Optional feature macro: ADC_CAPTURE_AUTO_EN (forced trigger after AUTO_TIMEOUT
// WAIT_TRIG cycles without a crossing).
// Ports: sys_clk/reset (sync, active-high); adc_data = NUM_CH packed samples;
//        trig_src/trig_slope/trig_level/pretrig = trigger config, latched on arm;
//        arm = start pulse; out_valid/out_ready/out_data/out_last = record stream;
//        busy = not idle; wave_number = records fully read out.
module adc_capture_engine
   import adc_capture_pkg::*;
#(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int PRE_MAX = DEF_PRE_MAX
`ifdef ADC_CAPTURE_AUTO_EN
   ,
   parameter int AUTO_TIMEOUT = DEF_AUTO_TIMEOUT
`endif
) (
   input  logic                                           sys_clk,
   input  logic                                           reset,
   input  logic [NUM_CH*DATA_W-1:0]                       adc_data,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] trig_src,
   input  logic                                           trig_slope,
   input  logic [DATA_W-1:0]                              trig_level,
   input  logic [$clog2(PRE_MAX+1)-1:0]                   pretrig,
   input  logic                                           arm,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic [NUM_CH*DATA_W-1:0]                       out_data,
   output logic                                           out_last,
   output logic                                           busy,
   output logic [15:0]                                    wave_number
);

   localparam int W     = NUM_CH * DATA_W;
   localparam int SRC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PRE_W = $clog2(PRE_MAX + 1);
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);

   cap_state_t        state;
   logic [W-1:0]      cur;
   logic [W-1:0]      prev;
   logic [SRC_W-1:0]  src_l;
   logic              slope_l;
   logic [DATA_W-1:0] level_l;
   logic [PRE_W-1:0]  p_l;
   logic [PRE_W-1:0]  p_clamped;
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     start;
   logic [AW-1:0]     trig_start;
   logic [AW-1:0]     rd_addr;
   logic [CW-1:0]     cnt;         // FILL: writes done; CAPTURE: writes remaining
   logic [CW-1:0]     fill_last;
   logic [CW-1:0]     rd_issued;
   logic              rd_pend;
   logic              rd_pend_last;
   logic [W-1:0]      ram_q;
   logic              skid_vld;
   logic              skid_last;
   logic [W-1:0]      skid_dat;
   logic [1:0]        occ;
   logic              we;
   logic              pop;
   logic              rd_issue;
   logic              fire_raw;
   logic              fire;
   logic [DATA_W-1:0] trig_cur;
   logic [DATA_W-1:0] trig_prev;

   logic [W-1:0]      mem [DEPTH];

   // Input register: cur is the sample written this cycle, prev the one before.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         cur  <= '0;
         prev <= '0;
      end else begin
         cur  <= adc_data;
         prev <= cur;
      end
   end

   // Trigger channel mux; an out-of-range select falls back to channel 0.
   always_comb begin
      trig_cur  = cur[DATA_W-1:0];
      trig_prev = prev[DATA_W-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
         if (SRC_W'(c) == src_l) begin
            trig_cur  = cur[c*DATA_W +: DATA_W];
            trig_prev = prev[c*DATA_W +: DATA_W];
         end
      end
   end

   edge_trigger #(.DATA_W(DATA_W)) u_edge_trigger (
      .prev  (trig_prev),
      .cur   (trig_cur),
      .level (level_l),
      .slope (slope_l),
      .fire  (fire_raw)
   );

`ifdef ADC_CAPTURE_AUTO_EN
   logic [31:0] auto_cnt;

   // Counts WAIT_TRIG cycles; held at zero elsewhere so it restarts on entry.
   always_ff @(posedge sys_clk) begin
      if (reset || state != ST_WAIT_TRIG) auto_cnt <= '0;
      else                                auto_cnt <= auto_cnt + 32'd1;
   end

   assign fire = fire_raw || (auto_cnt == 32'(AUTO_TIMEOUT - 1));
`else
   assign fire = fire_raw;
`endif

   assign p_clamped  = (pretrig > PRE_W'(PRE_MAX)) ? PRE_W'(PRE_MAX) : pretrig;
   assign fill_last  = (p_l == '0) ? '0 : CW'(p_l) - 1'b1;
   assign trig_start = AW'(sub_mod(32'(wptr), 32'(p_l), DEPTH));
   assign we         = (state == ST_FILL) || (state == ST_WAIT_TRIG) || (state == ST_CAPTURE);
   assign pop        = out_valid && out_ready;

   // Only issue a read if out + skid can absorb everything in flight after it.
   assign occ      = {1'b0, out_valid} + {1'b0, skid_vld} + {1'b0, rd_pend};
   assign rd_issue = (state == ST_READOUT) && (rd_issued < CW'(DEPTH)) &&
                     (occ <= ({1'b0, pop} + 2'd1));

   // Record buffer: contents are never cleared.
   always_ff @(posedge sys_clk) begin
      if (we)       mem[wptr] <= cur;
      if (rd_issue) ram_q     <= mem[rd_addr];
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         src_l        <= '0;
         slope_l      <= 1'b0;
         level_l      <= '0;
         p_l          <= '0;
         wptr         <= '0;
         start        <= '0;
         rd_addr      <= '0;
         cnt          <= '0;
         rd_issued    <= '0;
         rd_pend      <= 1'b0;
         rd_pend_last <= 1'b0;
         skid_vld     <= 1'b0;
         skid_last    <= 1'b0;
         skid_dat     <= '0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         out_data     <= '0;
         busy         <= 1'b0;
         wave_number  <= '0;
      end else begin
         if (we) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;

         if (rd_issue) begin
            rd_addr   <= (rd_addr == AW'(DEPTH - 1)) ? '0 : rd_addr + 1'b1;
            rd_issued <= rd_issued + 1'b1;
         end
         rd_pend      <= rd_issue;
         rd_pend_last <= rd_issue && (rd_issued == CW'(DEPTH - 1));

         // Output stage ordering: out, then skid, then the word leaving the RAM.
         if (!out_valid || out_ready) begin
            if (skid_vld) begin
               out_valid <= 1'b1;
               out_data  <= skid_dat;
               out_last  <= skid_last;
               skid_vld  <= rd_pend;
               skid_dat  <= ram_q;
               skid_last <= rd_pend_last;
            end else if (rd_pend) begin
               out_valid <= 1'b1;
               out_data  <= ram_q;
               out_last  <= rd_pend_last;
            end else begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         end else if (rd_pend) begin
            skid_vld  <= 1'b1;
            skid_dat  <= ram_q;
            skid_last <= rd_pend_last;
         end

         case (state)
            ST_IDLE: begin
               if (arm) begin
                  src_l     <= trig_src;
                  slope_l   <= trig_slope;
                  level_l   <= trig_level;
                  p_l       <= p_clamped;
                  cnt       <= '0;
                  rd_issued <= '0;
                  busy      <= 1'b1;
                  state     <= ST_FILL;
               end
            end
            ST_FILL: begin
               cnt <= cnt + 1'b1;
               if (cnt == fill_last) state <= ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
               if (fire) begin
                  start   <= trig_start;
                  rd_addr <= trig_start;
                  // The trigger sample is written now; with a single post-trigger
                  // sample the record is already complete.
                  if (CW'(p_l) == CW'(DEPTH - 1)) begin
                     state <= ST_READOUT;
                  end else begin
                     cnt   <= CW'(DEPTH) - CW'(p_l) - 1'b1;
                     state <= ST_CAPTURE;
                  end
               end
            end
            ST_CAPTURE: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  rd_addr <= start;
                  state   <= ST_READOUT;
               end
            end
            ST_READOUT: begin
               if (pop && out_last) begin
                  wave_number <= wave_number + 16'd1;
                  busy        <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_capture_engine.sv
// Directed bench for adc_capture_engine with the default parameter set.
// Drives generated ADC waveforms, captures each streamed record and compares
// it against hand-derived sample values and sample-index sequences.
module tb_adc_capture_engine;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic [27:0] adc_data;
   logic [0:0]  trig_src;
   logic        trig_slope;
   logic [13:0] trig_level;
   logic [6:0]  pretrig;
   logic        arm;
   logic        out_valid;
   logic        out_ready;
   logic [27:0] out_data;
   logic        out_last;
   logic        busy;
   logic [15:0] wave_number;

   int n_cmp = 0;
   int n_bad = 0;
   int gen_mode = 0;
   int n = 0;

   logic [27:0] rec [0:1023];
   int rec_n;
   int last_cnt;
   int last_idx;
   int stab_err;
   bit done;

   always #5 sys_clk = ~sys_clk;

   adc_capture_engine dut (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .adc_data    (adc_data),
      .trig_src    (trig_src),
      .trig_slope  (trig_slope),
      .trig_level  (trig_level),
      .pretrig     (pretrig),
      .arm         (arm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .wave_number (wave_number)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // mode 0: ch0 ramps 10/sample (mod 2^14), ch1 = 16383 - ch0
   // mode 1: both channels constant 5000
   // mode 2: ch0 sawtooth 0..990 period 100, ch1 = sample index
   function automatic logic [27:0] gen(input int mode, input int k);
      int a;
      int b;
      case (mode)
         0: begin a = (10 * k) % 16384; b = 16383 - a; end
         2: begin a = (k % 100) * 10;   b = k % 16384; end
         default: begin a = 5000; b = 5000; end
      endcase
      return {b[13:0], a[13:0]};
   endfunction

   task automatic tick();
      @(posedge sys_clk);
      #1;
      adc_data = gen(gen_mode, n);
      n++;
   endtask

   // Sample index restarts at 0 in the arm cycle, so the first sample written
   // in FILL is gen(mode, 0).
   task automatic start(input int mode, input logic src, input logic slope,
                        input logic [13:0] lvl, input logic [6:0] pre);
      tick();
      gen_mode   = mode;
      n          = 1;
      adc_data   = gen(mode, 0);
      trig_src   = src;
      trig_slope = slope;
      trig_level = lvl;
      pretrig    = pre;
      arm        = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic run_record(input string tag, input bit rnd, input int budget);
      bit          rdy;
      bit          stall;
      logic [27:0] held;
      rec_n    = 0;
      last_cnt = 0;
      last_idx = -1;
      stab_err = 0;
      done     = 1'b0;
      stall    = 1'b0;
      held     = '0;
      for (int c = 0; c < budget && !done; c++) begin
         tick();
         arm = 1'b0;
         if (stall) begin
            if (!out_valid || out_data != held) stab_err++;
            stall = 1'b0;
         end
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         out_ready = rdy;
         if (out_valid && rdy) begin
            if (rec_n < 1024) rec[rec_n] = out_data;
            if (out_last) begin
               last_cnt++;
               last_idx = rec_n;
               done = 1'b1;
            end
            rec_n++;
         end else if (out_valid) begin
            stall = 1'b1;
            held  = out_data;
         end
      end
      chk({tag, "_record_done"}, longint'(done), 1);
      if (done) begin
         tick();
         chk({tag, "_busy_end"}, longint'(busy), 0);
         chk({tag, "_valid_end"}, longint'(out_valid), 0);
      end
      if (rnd) chk({tag, "_stall_stable_errs"}, longint'(stab_err), 0);
   endtask

   // Word k of the record must be sample n0 + k of the generator.
   task automatic check_rec(input string tag, input int mode, input int n0);
      int bad;
      bad = 0;
      chk({tag, "_words"}, longint'(rec_n), 1000);
      chk({tag, "_last_idx"}, longint'(last_idx), 999);
      chk({tag, "_last_cnt"}, longint'(last_cnt), 1);
      for (int k = 0; k < 1000 && k < rec_n; k++)
         if (rec[k] != gen(mode, n0 + k)) bad++;
      chk({tag, "_seq_bad"}, longint'(bad), 0);
   endtask

   initial begin
      reset      = 1'b1;
      arm        = 1'b0;
      out_ready  = 1'b1;
      adc_data   = '0;
      trig_src   = '0;
      trig_slope = 1'b0;
      trig_level = '0;
      pretrig    = '0;
      repeat (3) tick();
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_last", longint'(out_last), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_wave", longint'(wave_number), 0);
      reset = 1'b0;
      repeat (4) tick();
      chk("idle_busy", longint'(busy), 0);

      // Rising on ch0 at 7000, 100 pre-trigger samples: trigger sample is n=700.
      start(0, 1'b0, 1'b0, 14'd7000, 7'd100);
      chk("t1_busy_rise", longint'(busy), 1);
      run_record("t1", 1'b0, 6000);
      check_rec("t1", 0, 600);
      chk("t1_w100_ch0", longint'(rec[100][13:0]), 7000);
      chk("t1_w99_ch0", longint'(rec[99][13:0]), 6990);
      chk("t1_wave", longint'(wave_number), 1);

      // Falling on ch1 at 9400, no pre-trigger: ch1 goes 9403 -> 9393 at n=699.
      // Config inputs and a stray arm after the latch must have no effect.
      start(0, 1'b1, 1'b1, 14'd9400, 7'd0);
      trig_level = 14'd0;
      trig_src   = 1'b0;
      trig_slope = 1'b0;
      pretrig    = 7'd50;
      arm        = 1'b1;
      run_record("t2", 1'b0, 6000);
      check_rec("t2", 0, 699);
      chk("t2_w0_ch1", longint'(rec[0][27:14]), 9393);
      chk("t2_w0_ch0", longint'(rec[0][13:0]), 6990);
      chk("t2_wave", longint'(wave_number), 2);

      // pretrig 120 clamps to 100; sawtooth crosses 500 at n=50 (FILL, ignored)
      // and again at n=150, which becomes record word 100.
      start(2, 1'b0, 1'b0, 14'd500, 7'd120);
      run_record("t3", 1'b0, 6000);
      check_rec("t3", 2, 50);
      chk("t3_w100_ch1", longint'(rec[100][27:14]), 150);
      chk("t3_w100_ch0", longint'(rec[100][13:0]), 500);
      chk("t3_w99_ch0", longint'(rec[99][13:0]), 490);
      chk("t3_wave", longint'(wave_number), 3);

      // Same as the first record with random consumer backpressure.
      start(0, 1'b0, 1'b0, 14'd7000, 7'd100);
      run_record("t4", 1'b1, 12000);
      check_rec("t4", 0, 600);
      chk("t4_wave", longint'(wave_number), 4);
      out_ready = 1'b1;

      // Reset in CAPTURE (trigger at n=700, capture runs to n=1599).
      start(0, 1'b0, 1'b0, 14'd7000, 7'd100);
      repeat (800) tick();
      chk("t5_busy_capture", longint'(busy), 1);
      reset = 1'b1;
      tick();
      chk("t5_rst_busy", longint'(busy), 0);
      chk("t5_rst_valid", longint'(out_valid), 0);
      chk("t5_rst_wave", longint'(wave_number), 0);
      reset = 1'b0;
      tick();
      start(0, 1'b0, 1'b0, 14'd7000, 7'd100);
      run_record("t5", 1'b0, 6000);
      check_rec("t5", 0, 600);
      chk("t5_w100_ch0", longint'(rec[100][13:0]), 7000);
      chk("t5_wave", longint'(wave_number), 1);

      // Constant input never crosses: the engine waits for a trigger forever.
      start(1, 1'b0, 1'b0, 14'd7000, 7'd100);
      repeat (3000) tick();
      chk("t6_busy_wait", longint'(busy), 1);
      chk("t6_valid_wait", longint'(out_valid), 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
